// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  // Step counter width for a DW-step operation.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client (master) and seq_divider (slave).
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) ();
  // Handshake: a rising edge of start while the divider is idle launches one
  // operation with the operands present on that edge; busy covers the run, and
  // done pulses for exactly one cycle when quotient/remainder/dbz update.
  // Edges of start while busy or done are dropped, never queued.
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;
  logic          busy;
  logic          done;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, dbz, busy, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, dbz, busy, done
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract the divisor when it fits.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   pr_i,
  input  logic          din_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   pr_o,
  output logic          q_o
);
  logic [VW+1:0] shifted;
  logic [VW+1:0] dv_ext;

  always_comb begin
    shifted = {pr_i, din_i};
    dv_ext  = {2'b00, divisor_i};
    q_o     = (shifted >= dv_ext);
    pr_o    = q_o ? (VW+1)'(shifted - dv_ext) : (VW+1)'(shifted);
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, DW steps per
// operation, results held in output registers until the next completion.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus,
  output div_state_e    state_dbg
);
  localparam int CW = cnt_width(DW);

  div_state_e    state_q, state_d;
  logic          start_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dq_q, dq_d;
  logic [VW-1:0] dv_q, dv_d;
  logic [VW:0]   pr_q, pr_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic [VW:0]   step_pr;
  logic          step_q;

  // dq holds the unconsumed dividend bits in its top and collects quotient bits at its bottom.
  div_step #(.VW(VW)) u_step (
    .pr_i      (pr_q),
    .din_i     (dq_q[DW-1]),
    .divisor_i (dv_q),
    .pr_o      (step_pr),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dv_d    = dv_q;
    pr_d    = pr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = (state_q == IDLE) && bus.start && !start_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          dq_d    = bus.dividend;
          dv_d    = bus.divisor;
          pr_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        pr_d  = step_pr;
        dq_d  = {dq_q[DW-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // A zero divisor still runs the full latency; its result is fixed.
          if (dv_q == '0) begin
            quo_d = '1;
            rem_d = '0;
            dbz_d = 1'b1;
          end else begin
            quo_d = {dq_q[DW-2:0], step_q};
            rem_d = step_pr[VW-1:0];
            dbz_d = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      dq_q    <= '0;
      dv_q    <= '0;
      pr_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      dv_q    <= dv_d;
      pr_q    <= pr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign state_dbg     = state_q;
endmodule
